// File: rtl/sha256_pipe_sched.sv
// Issue/retire scheduler for the unrolled double-SHA256 pipeline: sweeps a nonce range,
// drives the shared stage write enable and retires results in order. Optional abort: SHA_SCHED_ABORT_EN.
//
// state | meaning
// IDLE  | out of reset, waiting for start
// RUN   | issuing one nonce per advancing cycle
// DRAIN | no more issues, retiring in-flight results
// DONE  | sweep finished, results held until next start
module sha256_pipe_sched #(
  parameter int STAGES  = 64,
  parameter int NONCE_W = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               out_ready,
  input  logic               hit,
`ifdef SHA_SCHED_ABORT_EN
  input  logic               abort,
`endif
  output logic               pipe_write_en,
  output logic               issue_valid,
  output logic [NONCE_W-1:0] issue_nonce,
  output logic               out_valid,
  output logic [NONCE_W-1:0] out_nonce,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [STAGES-1:0]  vld, vld_nxt;
  logic [NONCE_W-1:0] issue_cnt, out_cnt, end_q;
  logic               adv, retire, start_ok, abort_w, abort_act, last_issue;

`ifdef SHA_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign out_valid     = vld[STAGES-1];
  assign adv           = !out_valid | out_ready;
  assign pipe_write_en = adv;
  assign issue_valid   = (state == S_RUN) & adv;
  assign retire        = out_valid & out_ready;
  assign busy          = (state == S_RUN) | (state == S_DRAIN);
  assign done          = (state == S_DONE);
  assign start_ok      = start & ((state == S_IDLE) | (state == S_DONE));
  assign abort_act     = abort_w & busy;
  assign last_issue    = issue_valid & (issue_cnt == end_q);
  assign issue_nonce   = issue_cnt;
  assign out_nonce     = out_cnt;
  assign vld_nxt       = adv ? {vld[STAGES-2:0], issue_valid} : vld;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_ok) state_nxt = S_RUN;
      S_RUN: begin
        if (abort_act)                         state_nxt = S_DONE;
        else if (last_issue || (retire && hit)) state_nxt = S_DRAIN;
      end
      // leave once the map, including this cycle's retire, has emptied
      S_DRAIN: begin
        if (abort_act)             state_nxt = S_DONE;
        else if (vld_nxt == '0)    state_nxt = S_DONE;
      end
      S_DONE:  if (start_ok) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      vld         <= '0;
      issue_cnt   <= '0;
      out_cnt     <= '0;
      end_q       <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
    end else begin
      state <= state_nxt;
      vld   <= abort_act ? '0 : vld_nxt;
      if (start_ok) begin
        issue_cnt   <= nonce_start;
        out_cnt     <= nonce_start;
        end_q       <= nonce_end;
        found       <= 1'b0;
        found_nonce <= '0;
      end else if (!abort_act) begin
        if (issue_valid) issue_cnt <= issue_cnt + 1'b1;
        if (retire)      out_cnt   <= out_cnt + 1'b1;
        if (retire && hit && !found) begin
          found       <= 1'b1;
          found_nonce <= out_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_sha256_pipe_sched.sv
// Scoreboard bench for sha256_pipe_sched with STAGES=4: directed sweeps, wrap, stall, hit, reset.
module tb_sha256_pipe_sched;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] nonce_start = '0, nonce_end = '0;
  logic        out_ready = 1'b1;
  logic        hit;
  logic        hit_en = 1'b0;
  logic [31:0] hit_target = '0;
  logic        pipe_write_en, issue_valid, out_valid, busy, done, found;
  logic [31:0] issue_nonce, out_nonce, found_nonce;
`ifdef SHA_SCHED_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_ret_cyc = 0;
  logic [31:0] exp_q[$];

  sha256_pipe_sched #(.STAGES(4), .NONCE_W(32)) dut (
    .CLK(CLK), .RST(RST), .start(start), .nonce_start(nonce_start), .nonce_end(nonce_end),
    .out_ready(out_ready), .hit(hit),
`ifdef SHA_SCHED_ABORT_EN
    .abort(abort),
`endif
    .pipe_write_en(pipe_write_en), .issue_valid(issue_valid), .issue_nonce(issue_nonce),
    .out_valid(out_valid), .out_nonce(out_nonce), .busy(busy), .done(done),
    .found(found), .found_nonce(found_nonce)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // target comparator stand-in
  assign hit = hit_en & out_valid & (out_nonce == hit_target);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pop and compare every retired result
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      last_ret_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %h expected none", out_nonce);
      end else begin
        chk("out_nonce", out_nonce, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_range(input logic [31:0] s, input logic [31:0] e);
    logic [31:0] n;
    n = s;
    exp_q.push_back(n);
    while (n != e) begin
      n = n + 1;
      exp_q.push_back(n);
    end
  endtask

  // leaves the caller at the first RUN cycle, just after its rising edge
  task automatic start_sweep(input logic [31:0] s, input logic [31:0] e);
    tick();
    start = 1'b1;
    nonce_start = s;
    nonce_end = e;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input logic exp_found, input logic [31:0] exp_fn);
    int k;
    k = 0;
    @(negedge CLK);
    while (!done && k < 200) begin
      @(negedge CLK);
      k++;
    end
    chk({name, "_done"}, {31'b0, done}, 32'd1);
    chk({name, "_done_timing"}, cyc, last_ret_cyc + 1);
    chk({name, "_busy"}, {31'b0, busy}, 32'd0);
    chk({name, "_found"}, {31'b0, found}, {31'b0, exp_found});
    chk({name, "_found_nonce"}, found_nonce, exp_fn);
    chk({name, "_left_in_queue"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    int t0, k;
    #1;
    chk("rst_pipe_write_en", {31'b0, pipe_write_en}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
    chk("rst_issue_nonce", issue_nonce, 32'd0);
    #20;
    RST = 1'b0;

    // basic sweep 0x10..0x13 with latency check
    push_range(32'h10, 32'h13);
    start_sweep(32'h10, 32'h13);
    @(negedge CLK);
    chk("first_issue_valid", {31'b0, issue_valid}, 32'd1);
    chk("first_issue_nonce", issue_nonce, 32'h10);
    chk("busy_in_run", {31'b0, busy}, 32'd1);
    t0 = cyc;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("latency", cyc - t0, 32'd4);
    wait_done("basic", 1'b0, 32'h0);

    // wrap through all-ones
    push_range(32'hFFFF_FFFE, 32'h1);
    start_sweep(32'hFFFF_FFFE, 32'h1);
    wait_done("wrap", 1'b0, 32'h0);

    // single nonce
    push_range(32'h50, 32'h50);
    start_sweep(32'h50, 32'h50);
    wait_done("single", 1'b0, 32'h0);

    // back-pressure: first result stalls three cycles
    push_range(32'h20, 32'h27);
    start_sweep(32'h20, 32'h27);
    repeat (4) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("stall_write_en", {31'b0, pipe_write_en}, 32'd0);
      chk("stall_issue_valid", {31'b0, issue_valid}, 32'd0);
      chk("stall_issue_nonce", issue_nonce, 32'h24);
      chk("stall_out_nonce", out_nonce, 32'h20);
      chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    end
    tick();
    out_ready = 1'b1;
    wait_done("stall", 1'b0, 32'h0);

    // hit on 0x12: issues through 0x16 happen before DRAIN
    hit_en = 1'b1;
    hit_target = 32'h12;
    push_range(32'h10, 32'h16);
    start_sweep(32'h10, 32'h1F);
    wait_done("hit", 1'b1, 32'h12);
    chk("hit_issue_stop", issue_nonce, 32'h17);
    hit_en = 1'b0;

    // reset mid-RUN with live stages
    push_range(32'h30, 32'h3F);
    start_sweep(32'h30, 32'h3F);
    tick();
    #2;
    RST = 1'b1;
    #1;
    chk("mid_rst_write_en", {31'b0, pipe_write_en}, 32'd1);
    chk("mid_rst_flags", {26'b0, issue_valid, out_valid, busy, done, found, 1'b0}, 32'd0);
    chk("mid_rst_issue_nonce", issue_nonce, 32'd0);
    chk("mid_rst_out_nonce", out_nonce, 32'd0);
    chk("mid_rst_found_nonce", found_nonce, 32'd0);
    exp_q.delete();
    tick();
    RST = 1'b0;
    push_range(32'h40, 32'h42);
    start_sweep(32'h40, 32'h42);
    wait_done("post_rst", 1'b0, 32'h0);

`ifdef SHA_SCHED_ABORT_EN
    start_sweep(32'h60, 32'h6F);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge CLK);
    chk("abort_done", {31'b0, done}, 32'd1);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("abort_no_out_valid", {31'b0, out_valid}, 32'd0);
      @(negedge CLK);
    end
    chk("abort_found", {31'b0, found}, 32'd0);
`endif

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
